// File: rtl/rs_gf_div_seq.sv
// Sequential GF(2^m) divider: odat = idat_a * idat_b^(2^m-2) by square-and-multiply.
// Optional RS_GF_DIV_FAST_PATH_EN: trivial operands (b==0, a==0, b==1) bypass the RUN phase.
module rs_gf_div_seq #(
    parameter int m      = 8,
    parameter int irrpol = 285
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         ival,
    input  logic [m-1:0] idat_a,
    input  logic [m-1:0] idat_b,
    output logic         ordy,
    output logic         oval,
    input  logic         irdy,
    output logic [m-1:0] odat,
    output logic         oerr
);

    localparam int CW = $clog2(m);
    localparam logic [m-1:0] POLY_LO = irrpol[m-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [m-1:0]  acc_q, acc_d;
    logic [m-1:0]  sq_q, sq_d;
    logic [m-1:0]  odat_q, odat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;
    logic          oerr_q, oerr_d;

    logic [m-1:0]  sq_in;
    logic [m-1:0]  sq_out;
    logic [m-1:0]  prod;

    // MSB-first shift-and-add multiply, reducing by the field polynomial each step.
    function automatic logic [m-1:0] gf_mult_a_by_b(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < m; i++) begin
            p = {p[m-2:0], 1'b0} ^ (p[m-1] ? POLY_LO : '0);
            if (b[m-1-i]) p = p ^ a;
        end
        return p;
    endfunction

    // Squarer input comes from the divisor at accept and from sq_q while iterating.
    assign sq_in  = (state_q == S_IDLE) ? idat_b : sq_q;
    assign sq_out = gf_mult_a_by_b(sq_in, sq_in);
    assign prod   = gf_mult_a_by_b(acc_q, sq_q);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            sq_q    <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            odat_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            odat_q  <= odat_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        odat_d  = odat_q;
        oerr_d  = oerr_q;

        case (state_q)
            S_IDLE: begin
                if (ival) begin
                    acc_d   = idat_a;
                    sq_d    = sq_out;
                    cnt_d   = CW'(m - 2);
                    zero_d  = (idat_b == '0);
                    state_d = S_RUN;
`ifdef RS_GF_DIV_FAST_PATH_EN
                    if (idat_b == '0) begin
                        odat_d  = '0;
                        oerr_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (idat_a == '0) begin
                        odat_d  = '0;
                        oerr_d  = 1'b0;
                        state_d = S_DONE;
                    end else if (idat_b == m'(1)) begin
                        odat_d  = idat_a;
                        oerr_d  = 1'b0;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = prod;
                sq_d  = sq_out;
                if (cnt_q == '0) begin
                    odat_d  = zero_q ? '0 : prod;
                    oerr_d  = zero_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (irdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ordy = (state_q == S_IDLE);
    assign oval = (state_q == S_DONE);
    assign odat = odat_q;
    assign oerr = oerr_q;

endmodule

// File: tb/tb_rs_gf_div_seq.sv
// Directed bench for rs_gf_div_seq (m=8, irrpol=0x11D); honours RS_GF_DIV_FAST_PATH_EN.
module tb_rs_gf_div_seq;

    logic       iclk = 1'b0;
    logic       irst_n;
    logic       ival;
    logic [7:0] idat_a;
    logic [7:0] idat_b;
    logic       ordy;
    logic       oval;
    logic       irdy;
    logic [7:0] odat;
    logic       oerr;

    int total = 0;
    int bad   = 0;

`ifdef RS_GF_DIV_FAST_PATH_EN
    localparam int FLAT = 1;
`else
    localparam int FLAT = 8;
`endif

    rs_gf_div_seq #(.m(8), .irrpol(285)) dut (
        .iclk  (iclk),
        .irst_n(irst_n),
        .ival  (ival),
        .idat_a(idat_a),
        .idat_b(idat_b),
        .ordy  (ordy),
        .oval  (oval),
        .irdy  (irdy),
        .odat  (odat),
        .oerr  (oerr)
    );

    always #5 iclk = ~iclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full carry-less product, then reduction by 0x11D from the top bit down.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    // Latency = edges after the accept edge until the edge that samples oval high.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic e, output int lat);
        int n;
        n = 0;
        @(negedge iclk);
        while (!ordy && n < 50) begin
            @(negedge iclk);
            n++;
        end
        if (!ordy) check_eq("ordy_timeout", 32'd0, 32'd1);
        ival   = 1'b1;
        idat_a = a;
        idat_b = b;
        @(posedge iclk);
        #1;
        ival = 1'b0;
        n = 0;
        while (!oval && n < 50) begin
            @(posedge iclk);
            #1;
            n++;
        end
        if (!oval) check_eq("oval_timeout", 32'd0, 32'd1);
        q   = odat;
        e   = oerr;
        lat = n + 1;
    endtask

    task automatic ack();
        irdy = 1'b1;
        @(posedge iclk);
        #1;
        irdy = 1'b0;
    endtask

    initial begin
        logic [7:0] q;
        logic       e;
        int         lat;
        logic [7:0] ra, rb;
        int         rise[$];
        logic       prev;

        irst_n = 1'b0;
        ival   = 1'b0;
        irdy   = 1'b0;
        idat_a = '0;
        idat_b = '0;
        #12;
        check_eq("rst_ordy", 32'(ordy), 32'd1);
        check_eq("rst_oval", 32'(oval), 32'd0);
        check_eq("rst_odat", 32'(odat), 32'h00);
        check_eq("rst_oerr", 32'(oerr), 32'd0);
        @(negedge iclk);
        irst_n = 1'b1;

        run_div(8'h02, 8'h02, q, e, lat);
        check_eq("div22_q", 32'(q), 32'h01);
        check_eq("div22_e", 32'(e), 32'd0);
        check_eq("div22_lat", 32'(lat), 32'd8);
        ack();

        // 0x01/0x02 = 0x8E, held under backpressure while ival pulses are ignored
        run_div(8'h01, 8'h02, q, e, lat);
        check_eq("div12_q", 32'(q), 32'h8E);
        check_eq("div12_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge iclk);
            ival   = 1'b1;
            idat_a = 8'(i * 37 + 3);
            idat_b = 8'(i * 11 + 1);
            @(posedge iclk);
            #1;
            check_eq("bp_oval", 32'(oval), 32'd1);
            check_eq("bp_ordy", 32'(ordy), 32'd0);
            check_eq("bp_odat", 32'(odat), 32'h8E);
            check_eq("bp_oerr", 32'(oerr), 32'd0);
        end
        ival = 1'b0;
        ack();
        check_eq("ack_oval", 32'(oval), 32'd0);
        check_eq("ack_ordy", 32'(ordy), 32'd1);

        // Asynchronous reset in the middle of RUN
        @(negedge iclk);
        ival   = 1'b1;
        idat_a = 8'h53;
        idat_b = 8'hCA;
        @(posedge iclk);
        #1;
        ival = 1'b0;
        @(posedge iclk);
        @(posedge iclk);
        #2;
        irst_n = 1'b0;
        #1;
        check_eq("mid_rst_ordy", 32'(ordy), 32'd1);
        check_eq("mid_rst_oval", 32'(oval), 32'd0);
        check_eq("mid_rst_odat", 32'(odat), 32'h00);
        @(negedge iclk);
        irst_n = 1'b1;
        run_div(8'h02, 8'h02, q, e, lat);
        check_eq("post_rst_q", 32'(q), 32'h01);
        ack();

        run_div(8'h05, 8'h00, q, e, lat);
        check_eq("zdiv_q", 32'(q), 32'h00);
        check_eq("zdiv_e", 32'(e), 32'd1);
        check_eq("zdiv_lat", 32'(lat), 32'(FLAT));
        ack();

        run_div(8'h00, 8'h07, q, e, lat);
        check_eq("zero_a_q", 32'(q), 32'h00);
        check_eq("zero_a_e", 32'(e), 32'd0);
        check_eq("zero_a_lat", 32'(lat), 32'(FLAT));
        ack();

        run_div(8'h9C, 8'h01, q, e, lat);
        check_eq("one_b_q", 32'(q), 32'h9C);
        check_eq("one_b_e", 32'(e), 32'd0);
        check_eq("one_b_lat", 32'(lat), 32'(FLAT));
        ack();

        for (int b = 1; b < 256; b++) begin
            run_div(8'h01, 8'(b), q, e, lat);
            check_eq("inv", 32'(ref_mul(q, 8'(b))), 32'h01);
            ack();
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            run_div(ra, rb, q, e, lat);
            check_eq("rand_div", 32'(ref_mul(q, rb)), 32'(ra));
            check_eq("rand_err", 32'(e), 32'd0);
            ack();
        end

        // Back-to-back with ival and irdy held high: one result every 9 cycles
        @(negedge iclk);
        idat_a = 8'h37;
        idat_b = 8'h59;
        ival   = 1'b1;
        irdy   = 1'b1;
        prev   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge iclk);
            #1;
            if (oval && !prev) begin
                rise.push_back(c);
                check_eq("b2b_q", 32'(ref_mul(odat, 8'h59)), 32'h37);
            end
            prev = oval;
        end
        ival = 1'b0;
        check_eq("b2b_count", 32'(rise.size() >= 3), 32'd1);
        for (int i = 1; i < rise.size(); i++)
            check_eq("b2b_period", 32'(rise[i] - rise[i-1]), 32'd9);
        repeat (20) @(posedge iclk);
        irdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
